// File: rtl/dsp48a1_slice_pkg.sv
// Shared constants for the DSP48A1 slice: OPMODE bit positions, X/Z mux encodings, datapath widths.
package dsp48a1_pkg;

  localparam int A_W = 18;
  localparam int M_W = 36;
  localparam int P_W = 48;

  localparam int PREADD_EN  = 4;
  localparam int CIN_BIT    = 5;
  localparam int PREADD_SUB = 6;
  localparam int POST_SUB   = 7;

  localparam logic [1:0] X_ZERO = 2'd0;
  localparam logic [1:0] X_M    = 2'd1;
  localparam logic [1:0] X_P    = 2'd2;
  localparam logic [1:0] X_DAB  = 2'd3;

  localparam logic [1:0] Z_ZERO = 2'd0;
  localparam logic [1:0] Z_PCIN = 2'd1;
  localparam logic [1:0] Z_P    = 2'd2;
  localparam logic [1:0] Z_C    = 2'd3;

endpackage

// File: rtl/dsp48a1_slice_stage_reg.sv
// One optional pipeline stage: clock-enabled register with async active-low clear, or a plain wire.
module dsp_stage_reg #(
  parameter int WIDTH  = 18,
  parameter int EN_REG = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (EN_REG == 1) begin : g_reg
      logic [WIDTH-1:0] r_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_q <= '0;
        else if (i_ce) r_q <= i_d;
      end
      assign o_q = r_q;
    end else begin : g_bypass
      logic w_unused;
      assign w_unused = ^{i_clk, i_rst_n, i_ce};
      assign o_q      = i_d;
    end
  endgenerate

endmodule

// File: rtl/dsp48a1_slice.sv
// Spartan-6 DSP48A1-equivalent slice: D+/-B pre-adder, 18x18 multiplier, 48-bit post-adder.
// Define DSP48A1_SLICE_PARAM_CHECK_EN to reject illegal parameter sets at elaboration.
module dsp48a1_slice
  import dsp48a1_pkg::*;
#(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT"
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [A_W-1:0]    i_a,
  input  logic [A_W-1:0]    i_b,
  input  logic [A_W-1:0]    i_bcin,
  input  logic [P_W-1:0]    i_c,
  input  logic [A_W-1:0]    i_d,
  input  logic [P_W-1:0]    i_pcin,
  input  logic              i_carryin,
  input  logic [7:0]        i_opmode,
  input  logic              i_cea,
  input  logic              i_ceb,
  input  logic              i_cec,
  input  logic              i_ced,
  input  logic              i_cecarryin,
  input  logic              i_cem,
  input  logic              i_ceopmode,
  input  logic              i_cep,
  output logic [A_W-1:0]    o_bcout,
  output logic [M_W-1:0]    o_m,
  output logic [P_W-1:0]    o_p,
  output logic [P_W-1:0]    o_pcout,
  output logic              o_carryout,
  output logic              o_carryoutf
);

  localparam bit LP_B_CASCADE = (B_INPUT == "CASCADE");
  localparam bit LP_CIN_PORT  = (CARRYINSEL == "CARRYIN");

`ifdef DSP48A1_SLICE_PARAM_CHECK_EN
  localparam bit LP_BAD_REG =
    (A0REG > 1) || (A0REG < 0) || (A1REG > 1) || (A1REG < 0) ||
    (B0REG > 1) || (B0REG < 0) || (B1REG > 1) || (B1REG < 0) ||
    (CREG > 1) || (CREG < 0) || (DREG > 1) || (DREG < 0) ||
    (MREG > 1) || (MREG < 0) || (PREG > 1) || (PREG < 0) ||
    (CARRYINREG > 1) || (CARRYINREG < 0) || (CARRYOUTREG > 1) || (CARRYOUTREG < 0) ||
    (OPMODEREG > 1) || (OPMODEREG < 0);
  generate
    if (LP_BAD_REG) begin : g_bad_reg
      $fatal(1, "dsp48a1_slice: register parameters must be 0 or 1");
    end
    if (!(CARRYINSEL == "OPMODE5" || CARRYINSEL == "CARRYIN")) begin : g_bad_cinsel
      $fatal(1, "dsp48a1_slice: CARRYINSEL must be OPMODE5 or CARRYIN");
    end
    if (!(B_INPUT == "DIRECT" || B_INPUT == "CASCADE")) begin : g_bad_binput
      $fatal(1, "dsp48a1_slice: B_INPUT must be DIRECT or CASCADE");
    end
    if (PREG == 0 && OPMODEREG == 0) begin : g_bad_loop
      $fatal(1, "dsp48a1_slice: PREG=0 with OPMODEREG=0 is not allowed");
    end
  endgenerate
`endif

  logic [A_W-1:0] w_b_src, w_b0, w_a0, w_a1, w_d, w_preadd, w_b1;
  logic [P_W-1:0] w_c, w_p, w_x, w_z;
  logic [M_W-1:0] w_mult, w_m;
  logic [7:0]     w_op;
  logic           w_cin_src, w_cin, w_co;
  logic [P_W:0]   w_post;

  assign w_b_src = LP_B_CASCADE ? i_bcin : i_b;

  dsp_stage_reg #(.WIDTH(A_W), .EN_REG(B0REG)) u_b0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ceb), .i_d(w_b_src), .o_q(w_b0));
  dsp_stage_reg #(.WIDTH(A_W), .EN_REG(A0REG)) u_a0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_cea), .i_d(i_a), .o_q(w_a0));
  dsp_stage_reg #(.WIDTH(A_W), .EN_REG(DREG)) u_d (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ced), .i_d(i_d), .o_q(w_d));
  dsp_stage_reg #(.WIDTH(P_W), .EN_REG(CREG)) u_c (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_cec), .i_d(i_c), .o_q(w_c));
  dsp_stage_reg #(.WIDTH(8), .EN_REG(OPMODEREG)) u_op (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ceopmode), .i_d(i_opmode), .o_q(w_op));

  assign w_preadd = !w_op[PREADD_EN]  ? w_b0 :
                    w_op[PREADD_SUB] ? (w_d - w_b0) : (w_d + w_b0);

  dsp_stage_reg #(.WIDTH(A_W), .EN_REG(B1REG)) u_b1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ceb), .i_d(w_preadd), .o_q(w_b1));
  dsp_stage_reg #(.WIDTH(A_W), .EN_REG(A1REG)) u_a1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_cea), .i_d(w_a0), .o_q(w_a1));

  assign w_mult = M_W'(w_b1) * M_W'(w_a1);

  dsp_stage_reg #(.WIDTH(M_W), .EN_REG(MREG)) u_m (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_cem), .i_d(w_mult), .o_q(w_m));

  always_comb begin
    w_x = '0;
    case (w_op[1:0])
      X_M:     w_x = P_W'(w_m);
      X_P:     w_x = w_p;
      X_DAB:   w_x = {w_d[11:0], w_a1, w_b1};
      default: w_x = '0;
    endcase
  end

  always_comb begin
    w_z = '0;
    case (w_op[3:2])
      Z_PCIN:  w_z = i_pcin;
      Z_P:     w_z = w_p;
      Z_C:     w_z = w_c;
      default: w_z = '0;
    endcase
  end

  assign w_cin_src = LP_CIN_PORT ? i_carryin : w_op[CIN_BIT];

  dsp_stage_reg #(.WIDTH(1), .EN_REG(CARRYINREG)) u_cin (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_cecarryin), .i_d(w_cin_src), .o_q(w_cin));

  // Bit 48 is the carry on add and the borrow on subtract.
  assign w_post = w_op[POST_SUB] ?
                  ({1'b0, w_z} - ({1'b0, w_x} + {{P_W{1'b0}}, w_cin})) :
                  ({1'b0, w_z} + {1'b0, w_x} + {{P_W{1'b0}}, w_cin});

  dsp_stage_reg #(.WIDTH(P_W), .EN_REG(PREG)) u_p (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_cep), .i_d(w_post[P_W-1:0]), .o_q(w_p));
  dsp_stage_reg #(.WIDTH(1), .EN_REG(CARRYOUTREG)) u_co (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_cep), .i_d(w_post[P_W]), .o_q(w_co));

  assign o_bcout     = w_b1;
  assign o_m         = w_m;
  assign o_p         = w_p;
  assign o_pcout     = w_p;
  assign o_carryout  = w_co;
  assign o_carryoutf = w_co;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Bench for dsp48a1_slice with default parameters: directed steady-state and clock-enable
// checks, then random traffic scored against a cycle-level reference model.
module tb_dsp48a1_slice;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] a, b, bcin, d;
  logic [47:0] c, pcin;
  logic        carryin;
  logic [7:0]  opmode;
  logic        cea, ceb, cec, ced, cecarryin, cem, ceopmode, cep;
  logic [17:0] bcout;
  logic [35:0] m;
  logic [47:0] p, pcout;
  logic        carryout, carryoutf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dsp48a1_slice dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_bcin(bcin), .i_c(c), .i_d(d),
    .i_pcin(pcin), .i_carryin(carryin), .i_opmode(opmode),
    .i_cea(cea), .i_ceb(ceb), .i_cec(cec), .i_ced(ced), .i_cecarryin(cecarryin),
    .i_cem(cem), .i_ceopmode(ceopmode), .i_cep(cep),
    .o_bcout(bcout), .o_m(m), .o_p(p), .o_pcout(pcout),
    .o_carryout(carryout), .o_carryoutf(carryoutf));

  typedef struct {
    logic [17:0] bcout;
    logic [35:0] m;
    logic [47:0] p;
    logic        co;
  } exp_t;
  exp_t sb_q[$];

  // Operands as captured by the input-side stages at one clock edge.
  typedef struct packed {
    logic [7:0]  op;
    logic [17:0] a;
    logic [17:0] d;
    logic [47:0] c;
  } cap_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rnd_bcout", 64'(bcout), 64'(e.bcout));
        chk("rnd_m", 64'(m), 64'(e.m));
        chk("rnd_p", 64'(p), 64'(e.p));
        chk("rnd_pcout", 64'(pcout), 64'(e.p));
        chk("rnd_carryout", 64'(carryout), 64'(e.co));
        chk("rnd_carryoutf", 64'(carryoutf), 64'(e.co));
      end
    end
  end

  initial begin : stim
    cap_t        h1, h2;
    logic [17:0] mdl_b1, b1n;
    logic [35:0] mdl_m, mn;
    logic [47:0] mdl_p, xv, zv;
    logic [48:0] sum;
    logic        mdl_co, cin;

    rst_n = 1'b0;
    a = 18'h3_1234; b = 18'h0_0777; bcin = 18'h1_1111; d = 18'h2_2222;
    c = 48'hABCD_0000_1234; pcin = 48'h1234_5678_9ABC; carryin = 1'b1; opmode = 8'hFF;
    {cea, ceb, cec, ced, cecarryin, cem, ceopmode, cep} = 8'hFF;
    settle(3);
    chk("rst_p", 64'(p), 64'd0);
    chk("rst_m", 64'(m), 64'd0);
    chk("rst_bcout", 64'(bcout), 64'd0);
    chk("rst_pcout", 64'(pcout), 64'd0);
    chk("rst_carryout", 64'(carryout), 64'd0);
    chk("rst_carryoutf", 64'(carryoutf), 64'd0);

    rst_n = 1'b1; opmode = 8'h00;
    settle(4);
    chk("op00_p", 64'(p), 64'd0);
    chk("op00_co", 64'(carryout), 64'd0);

    opmode = 8'h11; d = 18'd100; b = 18'd20; a = 18'd3; settle(5);
    chk("preadd_bcout", 64'(bcout), 64'd120);
    chk("preadd_m", 64'(m), 64'd360);
    chk("preadd_p", 64'(p), 64'd360);

    opmode = 8'h51; settle(5);
    chk("presub_bcout", 64'(bcout), 64'd80);
    chk("presub_m", 64'(m), 64'd240);
    chk("presub_p", 64'(p), 64'd240);

    opmode = 8'h0C; c = 48'd500; settle(5);
    chk("zc_p", 64'(p), 64'd500);
    opmode = 8'h2C; settle(5);
    chk("zc_cin_p", 64'(p), 64'd501);

    opmode = 8'h03; d = 18'd1; a = 18'd2; b = 18'd3; settle(5);
    chk("xdab_p", 64'(p), 64'd68720001027);
    chk("xdab_co", 64'(carryout), 64'd0);

    opmode = 8'h8D; c = 48'd10; a = 18'd2; b = 18'd3; settle(5);
    chk("sub_p", 64'(p), 64'd4);
    c = 48'd0; a = 18'd1; b = 18'd1; settle(5);
    chk("borrow_p", 64'(p), 64'hFFFF_FFFF_FFFF);
    chk("borrow_co", 64'(carryout), 64'd1);
    chk("borrow_cof", 64'(carryoutf), 64'd1);

    opmode = 8'h0C; c = 48'd500; settle(5);
    cep = 1'b0; c = 48'd9; settle(4);
    chk("cep_hold_p", 64'(p), 64'd500);
    cep = 1'b1; settle(4);
    chk("cep_load_p", 64'(p), 64'd9);
    cec = 1'b0; c = 48'd77; settle(4);
    chk("cec_hold_p", 64'(p), 64'd9);
    cec = 1'b1; settle(4);
    chk("cec_load_p", 64'(p), 64'd77);
    ceopmode = 1'b0; opmode = 8'h00; settle(4);
    chk("ceop_hold_p", 64'(p), 64'd77);
    ceopmode = 1'b1; settle(4);
    chk("ceop_load_p", 64'(p), 64'd0);

    opmode = 8'h01; a = 18'd3; b = 18'd20; settle(5);
    chk("xm_m", 64'(m), 64'd60);
    cem = 1'b0; a = 18'd5; settle(4);
    chk("cem_hold_m", 64'(m), 64'd60);
    cem = 1'b1; settle(4);
    chk("cem_load_m", 64'(m), 64'd100);
    ceb = 1'b0; b = 18'd21; settle(4);
    chk("ceb_hold_bcout", 64'(bcout), 64'd20);
    ceb = 1'b1; b = 18'd20; settle(4);
    cea = 1'b0; a = 18'd7; settle(4);
    chk("cea_hold_m", 64'(m), 64'd100);
    cea = 1'b1; settle(4);
    chk("cea_load_m", 64'(m), 64'd140);

    opmode = 8'h11; d = 18'd100; b = 18'd20; settle(5);
    chk("ced_base_bcout", 64'(bcout), 64'd120);
    ced = 1'b0; d = 18'd5; settle(4);
    chk("ced_hold_bcout", 64'(bcout), 64'd120);
    ced = 1'b1;

    opmode = 8'h2C; c = 48'd500; settle(5);
    cecarryin = 1'b0; opmode = 8'h0C; settle(4);
    chk("cecin_hold_p", 64'(p), 64'd501);
    cecarryin = 1'b1; settle(4);
    chk("cecin_load_p", 64'(p), 64'd500);

    h1 = '0; h2 = '0; mdl_b1 = '0; mdl_m = '0; mdl_p = '0; mdl_co = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      rst_n   = (k < 2) ? 1'b0 : ($urandom_range(0, 49) != 0);
      opmode  = 8'($urandom);
      a       = 18'($urandom);
      b       = 18'($urandom);
      bcin    = 18'($urandom);
      d       = 18'($urandom);
      c       = {16'($urandom), 32'($urandom)};
      pcin    = {16'($urandom), 32'($urandom)};
      carryin = 1'($urandom);
      if (!rst_n) begin
        h1 = '0; h2 = '0; mdl_b1 = '0; mdl_m = '0; mdl_p = '0; mdl_co = 1'b0;
      end else begin
        cin = h2.op[5];
        if (h1.op[4]) b1n = h1.op[6] ? (h1.d - b) : (h1.d + b);
        else          b1n = b;
        mn = 36'(mdl_b1) * 36'(h1.a);
        case (h1.op[1:0])
          2'd0:    xv = '0;
          2'd1:    xv = 48'(mdl_m);
          2'd2:    xv = mdl_p;
          default: xv = {h1.d[11:0], h1.a, mdl_b1};
        endcase
        case (h1.op[3:2])
          2'd0:    zv = '0;
          2'd1:    zv = pcin;
          2'd2:    zv = mdl_p;
          default: zv = h1.c;
        endcase
        if (h1.op[7]) sum = {1'b0, zv} - ({1'b0, xv} + 49'(cin));
        else          sum = {1'b0, zv} + {1'b0, xv} + 49'(cin);
        mdl_b1 = b1n;
        mdl_m  = mn;
        mdl_p  = sum[47:0];
        mdl_co = sum[48];
        h2 = h1;
        h1 = '{op: opmode, a: a, d: d, c: c};
      end
      sb_q.push_back('{bcout: mdl_b1, m: mdl_m, p: mdl_p, co: mdl_co});
    end

    settle(3);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
